uart_tx_queue: RTL and testbench
================================

# uart_tx_queue

Downstream stage of the change-detecting send logic. Takes the byte that logic presents and drives it onto the serial TX line as an 8N1 UART frame. A 4-entry FIFO absorbs back-to-back updates, so a second traveller/machine change is not lost while a frame is on the wire. `data_in_ready` is returned upstream as the per-byte acknowledge.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: `uart_clk` cycles per serial bit (100 MHz / 115200). Legal range ≥ 2.
- `FIFO_DEPTH`, default 4: byte entries. Must be a power of 2, ≥ 2.

Ports:
- `uart_clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: synchronous, active-high reset.
- `output_data` input 8: byte offered by upstream. Value 0 means "nothing to send".
- `data_in_ready` output 1: one-cycle pulse; the byte on `output_data` was written to the FIFO on this edge.
- `tx` output 1: serial line, idle high.
- `tx_busy` output 1: high while a frame is being shifted or the FIFO is non-empty.
- `fifo_count` output 3: current FIFO occupancy, 0..FIFO_DEPTH.

## Operation
Reset values: `tx`=1, `data_in_ready`=0, `tx_busy`=0, `fifo_count`=0, state IDLE, `armed`=1, `last_byte`=0.

Accept rule, evaluated every edge:
- `push` = `armed` & (`output_data` != 0) & (`fifo_count` < FIFO_DEPTH), using pre-edge count.
- On `push`: write the byte at the write pointer, pulse `data_in_ready`, set `last_byte` = byte, clear `armed`.
- Re-arm (`armed`←1) on any edge where `output_data` == 0 or `output_data` != `last_byte`. This prevents a held byte from being queued twice.
- A nonzero byte offered while the FIFO is full is not accepted and gets no pulse. Upstream holds it; it is accepted once space frees.
- Same-edge push and pop: both happen, and `fifo_count` is unchanged. A pop frees space only for the following edge.
- Pointers wrap modulo FIFO_DEPTH.

TX FSM (states IDLE, START, DATA, PARITY*, STOP), with baud counter `bcnt` and bit index `bidx` (0..7):
- IDLE: `tx`=1. If the FIFO is non-empty, pop into shift register, `bcnt`←0, go to START.
- START: `tx`=0 for CLKS_PER_BIT cycles, then go to DATA with `bidx`=0.
- DATA: `tx`=shift[bidx], sent LSB first, each bit for CLKS_PER_BIT cycles. After bit 7 go to PARITY*, or to STOP if parity is compiled out.
- STOP: `tx`=1 for CLKS_PER_BIT cycles. On the final cycle, if the FIFO is non-empty, pop and go directly to START (back-to-back frames with no extra idle); otherwise go to IDLE.
- `bcnt` counts 0..CLKS_PER_BIT-1 and is reset at each bit boundary. Its width is $clog2(CLKS_PER_BIT).
- `rst` mid-frame: the frame is aborted, `tx` returns to 1 on the next edge, and FIFO contents are discarded.

## Timing
- Accept latency: byte valid before edge E0 → `data_in_ready`=1 during the cycle after E0.
- Start latency (empty FIFO, IDLE): pop at E1, so `tx` falls after E1. This is 1 cycle after accept.
- Frame length: 10×CLKS_PER_BIT cycles (11× with parity). All outputs are registered.
- `tx_busy` = (state != IDLE) | (`fifo_count` != 0), registered alongside the state.

## Configuration
- `UART_TX_PARITY_EN` defined: the PARITY state is compiled in. It sends one even-parity bit (XOR of the 8 data bits) for CLKS_PER_BIT cycles between DATA and STOP, giving an 8E1 frame of 11 bits.
- Not defined: no PARITY state; 8N1, 10-bit frame.

## Test plan
- Reset, then 20 idle cycles → `tx`=1, `tx_busy`=0, `fifo_count`=0, no `data_in_ready` pulse.
- CLKS_PER_BIT=4, offer 0xA5 and hold → exactly one `data_in_ready` pulse. `tx` shows 0, 1,0,1,0,0,1,0,1, then 1, each level for 4 cycles, 40 cycles total. No second frame while the byte is held.
- Offer 0x11, then 0, then 0x11 again → two frames of 0x11 (re-arm through 0).
- Offer 0x01..0x06 in succession, each held until acked → 0x01 goes straight to the shifter, the FIFO holds 4, and the next byte is blocked with no ack until the first STOP pop. Frames follow back-to-back with no idle gap, all 6 bytes in order.
- Assert `rst` midway through DATA of 0xFF with 2 bytes queued → `tx`=1 the next cycle, `fifo_count`=0, no further frames.
- With `UART_TX_PARITY_EN`, send 0x07 → parity bit 1, frame 44 cycles at CLKS_PER_BIT=4. Send 0x03 → parity bit 0.

Source files
------------

// File: rtl/uart_tx_queue.sv
// uart_tx_queue: FIFO-buffered UART transmitter that queues each new upstream byte once and sends it 8N1.
// Define UART_TX_PARITY_EN to add an even-parity bit (8E1, 11-bit frame).
`timescale 1ns/1ps
module uart_tx_queue #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       uart_clk,
  input  logic       rst,
  input  logic [7:0] output_data,
  output logic       data_in_ready,
  output logic       tx,
  output logic       tx_busy,
  output logic [2:0] fifo_count
);

  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [BW-1:0] BCNT_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
`ifdef UART_TX_PARITY_EN
    S_PARITY,
`endif
    S_STOP
  } state_t;

  function automatic logic even_parity(input logic [7:0] b);
    return ^b;
  endfunction

  state_t        state_q, state_d;
  logic [BW-1:0] bcnt_q, bcnt_d;
  logic [2:0]    bidx_q, bidx_d;
  logic [7:0]    shift_q, shift_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          rdy_q;
  logic          armed_q, armed_d;
  logic [7:0]    last_q, last_d;
  logic [PW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0] count_q, count_d;
  logic [7:0]    mem [FIFO_DEPTH];
  logic          push, pop, bit_end;

  // Accept side: a byte is queued once, then ignored until it changes or drops to zero.
  always_comb begin
    push    = armed_q && (output_data != 8'd0) && (count_q < DEPTH_C);
    armed_d = armed_q;
    last_d  = last_q;
    if (push) begin
      armed_d = 1'b0;
      last_d  = output_data;
    end else if ((output_data == 8'd0) || (output_data != last_q)) begin
      armed_d = 1'b1;
    end
    wptr_d = push ? wptr_q + PW'(1) : wptr_q;
    rptr_d = pop  ? rptr_q + PW'(1) : rptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Transmit FSM; the STOP bit's last cycle pops directly into START for gapless frames.
  always_comb begin
    state_d = state_q;
    bcnt_d  = bcnt_q;
    bidx_d  = bidx_q;
    shift_d = shift_q;
    pop     = 1'b0;
    bit_end = (bcnt_q == BCNT_LAST);
    case (state_q)
      S_IDLE: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          shift_d = mem[rptr_q];
          bcnt_d  = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (bit_end) begin
          bcnt_d  = '0;
          bidx_d  = '0;
          state_d = S_DATA;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      S_DATA: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (bidx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bidx_d = bidx_q + 3'd1;
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      S_PARITY: begin
        if (bit_end) begin
          bcnt_d  = '0;
          state_d = S_STOP;
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          bcnt_d = '0;
          if (count_q != '0) begin
            pop     = 1'b1;
            shift_d = mem[rptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          bcnt_d = bcnt_q + BW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shift_d[bidx_d];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = even_parity(shift_d);
`endif
      default:  tx_d = 1'b1;
    endcase
    busy_d = (state_d != S_IDLE) || (count_d != '0);
  end

  always_ff @(posedge uart_clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      bcnt_q  <= '0;
      bidx_q  <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      armed_q <= 1'b1;
      last_q  <= '0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      bcnt_q  <= bcnt_d;
      bidx_q  <= bidx_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rdy_q   <= push;
      armed_q <= armed_d;
      last_q  <= last_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Datapath storage carries no reset; control state alone decides what is valid.
  always_ff @(posedge uart_clk) begin
    shift_q <= shift_d;
    if (push) mem[wptr_q] <= output_data;
  end

  assign data_in_ready = rdy_q;
  assign tx            = tx_q;
  assign tx_busy       = busy_q;
  assign fifo_count    = 3'(count_q);

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue: a line monitor decodes each frame and pops the expected byte.
`timescale 1ns/1ps
module tb_uart_tx_queue;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       uart_clk;
  logic       rst;
  logic [7:0] output_data;
  logic       data_in_ready;
  logic       tx;
  logic       tx_busy;
  logic [2:0] fifo_count;

  uart_tx_queue #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(4)) dut (
    .uart_clk      (uart_clk),
    .rst           (rst),
    .output_data   (output_data),
    .data_in_ready (data_in_ready),
    .tx            (tx),
    .tx_busy       (tx_busy),
    .fifo_count    (fifo_count)
  );

  int         n_cmp = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         ack_cnt = 0;
  int         n_spurious = 0;
  logic [7:0] exp_q[$];
  int         starts[$];

  initial begin
    uart_clk = 1'b0;
    forever #5 uart_clk = ~uart_clk;
  end

  always @(posedge uart_clk) cyc <= cyc + 1;

  always @(negedge uart_clk) if (data_in_ready === 1'b1) ack_cnt <= ack_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic int start_of(input int idx);
    if (idx >= 0 && idx < starts.size()) return starts[idx];
    return -1;
  endfunction

  // Line monitor: samples every cycle of a frame, requires each bit level to hold for CPB cycles.
  initial begin : monitor
    logic [NB-1:0] lv;
    logic          stable;
    logic          aborted;
    logic [7:0]    b;
    logic [7:0]    e;
    forever begin
      @(negedge uart_clk);
      if (rst === 1'b0 && tx === 1'b0) begin
        starts.push_back(cyc);
        stable  = 1'b1;
        aborted = 1'b0;
        lv      = '0;
        for (int i = 0; i < FRAME; i++) begin
          if (i != 0) @(negedge uart_clk);
          if (rst !== 1'b0) begin
            aborted = 1'b1;
            break;
          end
          if (i % CPB == 0) lv[i / CPB] = tx;
          else if (tx !== lv[i / CPB]) stable = 1'b0;
        end
        if (!aborted) begin
          b = lv[8:1];
          check("start_bit", 32'(lv[0]), 32'd0);
          check("stop_bit", 32'(lv[NB-1]), 32'd1);
          check("bit_hold", 32'(stable), 32'd1);
`ifdef UART_TX_PARITY_EN
          check("parity_bit", 32'(lv[9]), 32'(^b));
`endif
          if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("frame_byte", 32'(b), 32'(e));
          end else begin
            n_spurious++;
          end
        end
      end
    end
  end

  task automatic offer(input logic [7:0] b, input bit expect_frame, output int ack_at);
    @(posedge uart_clk);
    #1;
    output_data = b;
    if (expect_frame) exp_q.push_back(b);
    ack_at = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge uart_clk);
      if (data_in_ready === 1'b1) begin
        ack_at = cyc;
        break;
      end
    end
    check("ack_seen", 32'(ack_at >= 0), 32'd1);
  endtask

  task automatic wait_idle(output int at);
    at = -1;
    for (int i = 0; i < 2000; i++) begin
      @(negedge uart_clk);
      if (tx_busy === 1'b0 && tx === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check("idle_reached", 32'(at >= 0), 32'd1);
  endtask

  task automatic drive(input logic [7:0] b);
    @(posedge uart_clk);
    #1;
    output_data = b;
  endtask

  initial begin : main
    int a, a0, f0, s, idle_at, acks0;
    rst = 1'b1;
    output_data = 8'd0;
    repeat (3) @(posedge uart_clk);
    #1;
    rst = 1'b0;

    // Reset state and quiet idle.
    @(negedge uart_clk);
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ready", 32'(data_in_ready), 32'd0);
    repeat (20) @(negedge uart_clk);
    check("idle_tx", 32'(tx), 32'd1);
    check("idle_busy", 32'(tx_busy), 32'd0);
    check("idle_no_ack", 32'(ack_cnt), 32'd0);
    check("idle_no_frame", 32'(starts.size()), 32'd0);

    // Single held byte: one ack, one frame, exact latency and length.
    a0 = ack_cnt;
    f0 = starts.size();
    offer(8'hA5, 1'b1, a);
    check("a5_count_at_ack", 32'(fifo_count), 32'd1);
    check("a5_busy_at_ack", 32'(tx_busy), 32'd1);
    wait_idle(idle_at);
    check("a5_start_latency", 32'(start_of(f0)), 32'(a + 1));
    check("a5_frame_len", 32'(idle_at - start_of(f0)), 32'(FRAME));
    repeat (20) @(negedge uart_clk);
    check("a5_one_ack", 32'(ack_cnt - a0), 32'd1);
    check("a5_one_frame", 32'(starts.size() - f0), 32'd1);
    drive(8'd0);
    repeat (3) @(negedge uart_clk);

    // Same byte twice, re-armed through zero.
    f0 = starts.size();
    offer(8'h11, 1'b1, a);
    drive(8'd0);
    repeat (2) @(posedge uart_clk);
    offer(8'h11, 1'b1, a);
    drive(8'd0);
    wait_idle(idle_at);
    check("rearm_two_frames", 32'(starts.size() - f0), 32'd2);

    // Burst of six: FIFO fills, sixth byte waits for the first STOP pop.
    f0 = starts.size();
    for (int k = 1; k <= 5; k++) offer(8'(k), 1'b1, a);
    check("burst_fifo_full", 32'(fifo_count), 32'd4);
    drive(8'h06);
    exp_q.push_back(8'h06);
    acks0 = ack_cnt;
    repeat (8) @(negedge uart_clk);
    check("burst_blocked_no_ack", 32'(ack_cnt - acks0), 32'd0);
    check("burst_blocked_count", 32'(fifo_count), 32'd4);
    a = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge uart_clk);
      if (data_in_ready === 1'b1) begin
        a = cyc;
        break;
      end
    end
    check("burst_late_ack", 32'(a), 32'(start_of(f0) + FRAME + 1));
    drive(8'd0);
    wait_idle(idle_at);
    check("burst_six_frames", 32'(starts.size() - f0), 32'd6);
    for (int k = 1; k < 6; k++)
      check("burst_b2b_gap", 32'(start_of(f0 + k) - start_of(f0 + k - 1)), 32'(FRAME));

    // Reset in the middle of a frame with two bytes queued.
    f0 = starts.size();
    offer(8'hFF, 1'b0, a);
    offer(8'h21, 1'b0, a);
    offer(8'h22, 1'b0, a);
    s = start_of(f0);
    for (int i = 0; i < 100 && cyc < s + 18; i++) @(negedge uart_clk);
    check("pre_rst_count", 32'(fifo_count), 32'd2);
    @(posedge uart_clk);
    #1;
    rst = 1'b1;
    output_data = 8'd0;
    @(negedge uart_clk);
    @(negedge uart_clk);
    check("abort_tx", 32'(tx), 32'd1);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_busy", 32'(tx_busy), 32'd0);
    @(posedge uart_clk);
    #1;
    rst = 1'b0;
    repeat (60) @(negedge uart_clk);
    check("abort_no_more_frames", 32'(starts.size() - f0), 32'd1);
    check("abort_tx_idle", 32'(tx), 32'd1);

    // Parity-sensitive bytes (odd and even bit count).
    f0 = starts.size();
    offer(8'h07, 1'b1, a);
    drive(8'd0);
    wait_idle(idle_at);
    check("b07_frame_len", 32'(idle_at - start_of(f0)), 32'(FRAME));
    offer(8'h03, 1'b1, a);
    drive(8'd0);
    wait_idle(idle_at);
    check("b03_frame_len", 32'(idle_at - start_of(f0 + 1)), 32'(FRAME));

    repeat (5) @(negedge uart_clk);
    check("no_spurious_frames", 32'(n_spurious), 32'd0);
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
